// File: rtl/video_timing_if.sv
// Pixel-side bundle of the video timing generator: coordinates out,
// fixed-latency RGB back in, aligned blank/sync/rgb out to TMDS.
interface video_timing_if;
  logic [11:0] x;
  logic [11:0] y;
  logic        active;
  logic        frame;
  logic [23:0] rgb_in;
  logic        blank;
  logic [1:0]  sync;
  logic [23:0] rgb;

  modport master (
    output x, y, active, frame,
    output blank, sync, rgb,
    input  rgb_in
  );

  modport slave (
    input  x, y, active, frame,
    input  blank, sync, rgb,
    output rgb_in
  );
endinterface

// File: rtl/video_timing.sv
// Pixel-clock raster counters plus a fixed-latency aligner that
// registers blank/sync/rgb together for the TMDS encoders.
module video_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int LATENCY  = 2
) (
  input  logic           clock,
  input  logic           reset,
  video_timing_if.master vif
);

  localparam int HT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [11:0] HL  = 12'(HT - 1);
  localparam logic [11:0] VL  = 12'(VT - 1);
  localparam logic [12:0] HA  = 13'(H_ACTIVE);
  localparam logic [12:0] VA  = 13'(V_ACTIVE);
  localparam logic [12:0] HS0 = 13'(H_ACTIVE + H_FRONT);
  localparam logic [12:0] HS1 = 13'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [12:0] VS0 = 13'(V_ACTIVE + V_FRONT);
  localparam logic [12:0] VS1 = 13'(V_ACTIVE + V_FRONT + V_SYNC);

  if (HT > 4096 || VT > 4096) begin : g_size_err
    $error("video_timing: HT/VT exceed 4096");
  end
  if (LATENCY < 0 || LATENCY > 15) begin : g_lat_err
    $error("video_timing: LATENCY out of range 0..15");
  end

  logic        r_run;
  logic [11:0] r_x;
  logic [11:0] r_y;
  logic        r_act;
  logic        r_frm;
  logic        r_hs;
  logic        r_vs;

  logic [11:0] w_nx;
  logic [11:0] w_ny;
  logic [12:0] w_nx13;
  logic [12:0] w_ny13;
  logic [2:0]  w_f;
  logic [2:0]  w_d;

  logic        r_blank;
  logic [1:0]  r_sync;
  logic [23:0] r_rgb;

  // First edge after reset presents (0,0) rather than advancing.
  always_comb begin
    w_nx = 12'd0;
    w_ny = 12'd0;
    if (r_run) begin
      if (r_x == HL) begin
        w_nx = 12'd0;
        w_ny = (r_y == VL) ? 12'd0 : r_y + 12'd1;
      end else begin
        w_nx = r_x + 12'd1;
        w_ny = r_y;
      end
    end
  end

  assign w_nx13 = {1'b0, w_nx};
  assign w_ny13 = {1'b0, w_ny};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_run <= 1'b0;
      r_x   <= 12'd0;
      r_y   <= 12'd0;
      r_act <= 1'b0;
      r_frm <= 1'b0;
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
    end else begin
      r_run <= 1'b1;
      r_x   <= w_nx;
      r_y   <= w_ny;
      r_act <= (w_nx13 < HA) && (w_ny13 < VA);
      r_frm <= (w_nx == 12'd0) && (w_ny == 12'd0);
      r_hs  <= (w_nx13 >= HS0) && (w_nx13 < HS1);
      r_vs  <= (w_ny13 >= VS0) && (w_ny13 < VS1);
    end
  end

  // Flags travel as "asserted" bits; polarity is applied at the output.
  assign w_f = {r_vs, r_hs, r_act};

  if (LATENCY == 0) begin : g_nodly
    assign w_d = w_f;
  end else begin : g_dly
    logic [2:0] r_sr [LATENCY];

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < LATENCY; i++) begin
          r_sr[i] <= 3'b000;
        end
      end else begin
        r_sr[0] <= w_f;
        for (int i = 1; i < LATENCY; i++) begin
          r_sr[i] <= r_sr[i-1];
        end
      end
    end

    assign w_d = r_sr[LATENCY-1];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_blank <= 1'b1;
      r_sync  <= {~V_POL, ~H_POL};
      r_rgb   <= 24'd0;
    end else begin
      r_blank <= ~w_d[0];
      r_sync  <= {w_d[2] ? V_POL : ~V_POL,
                  w_d[1] ? H_POL : ~H_POL};
      r_rgb   <= w_d[0] ? vif.rgb_in : 24'd0;
    end
  end

  assign vif.x      = r_x;
  assign vif.y      = r_y;
  assign vif.active = r_act;
  assign vif.frame  = r_frm;
  assign vif.blank  = r_blank;
  assign vif.sync   = r_sync;
  assign vif.rgb    = r_rgb;

endmodule
